regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
// - Parametrised multi-port RISC-V integer register file for the single-cycle core; drop-in successor
//   to the current 3-port file.
// - Adds: x0 hardwired to zero, synchronous clear, N read ports, write-to-read bypass, M debug taps.
// - Adds a valid/ready dump engine that streams every register out for testbench/debug checking.
// PARAMETERS
// - ADDRESS_WIDTH  5       register index width; DEPTH = 2**ADDRESS_WIDTH
// - DATA_WIDTH     32      register width
// - NUM_RD         2       read ports, >=1
// - BYPASS         1       1: same-cycle write visible on read ports; 0: registered value only
// - NUM_TAPS       3       debug tap outputs, >=1
// - TAP_ADDRS      {5'd28,5'd11,5'd10}  packed tap indices; tap k = TAP_ADDRS[k*AW +: AW] (t3,a1,a0)
// PORTS
// - clk         in   1               rising-edge clock
// - rst_n       in   1               synchronous active-low reset
// - rd_addr     in   NUM_RD*AW       packed read indices; port p = [p*AW +: AW]
// - rd_data     out  NUM_RD*DW       packed read data, combinational
// - we          in   1               write enable
// - wr_addr     in   AW              write index
// - wr_data     in   DW              write data
// - tap         out  NUM_TAPS*DW     packed registered contents of TAP_ADDRS entries
// - dump_start  in   1               begin full-file dump (pulse)
// - dump_busy   out  1               dump engine not IDLE
// - dump_valid  out  1               dump beat valid
// - dump_ready  in   1               consumer accepts beat
// - dump_idx    out  AW              index of current beat
// - dump_data   out  DW              snapshot of register dump_idx
// - dump_last   out  1               current beat is index DEPTH-1
// BEHAVIOUR
// - Reset: rst_n low at posedge -> all entries 0, dump state IDLE, dump_valid/busy/last 0, dump_idx 0,
//   dump_data 0. Reset overrides a same-cycle write and aborts a dump mid-stream (no further beats).
// - Write: on posedge with we=1 and wr_addr!=0, entry[wr_addr] <= wr_data. Writes to x0 dropped.
// - Read: rd_data[p] = 0 if rd_addr[p]==0; else if BYPASS && we && wr_addr==rd_addr[p] -> wr_data;
//   else entry[rd_addr[p]]. Zero latency. Read ports independent; all may alias.
// - Taps: entry value, no bypass; tap of index 0 always 0.
// - Dump FSM: IDLE -> SCAN -> IDLE.
//   - IDLE: dump_start=1 -> SCAN next cycle; dump_valid=1, dump_idx=0, dump_data=0.
//   - SCAN: dump_data is a register snapshot, stable while dump_valid && !dump_ready.
//     valid&&ready and idx<DEPTH-1 -> idx+1, dump_data <= entry[idx+1], with bypass of a same-cycle
//     write to idx+1 (always, independent of BYPASS). valid&&ready at DEPTH-1 -> IDLE, valid 0.
//   - Writes to an already-snapshotted index are not reflected in the current beat.
//   - dump_start ignored while busy. dump_last = valid && idx==DEPTH-1.
//   - Throughput 1 beat/cycle with ready held high: DEPTH beats in DEPTH cycles after start.
// - Writes and reads proceed normally during a dump; the dump never stalls the core.
// STRUCTURE
// - Package regfile_pkg: ABI index constants (REG_ZERO=0, REG_A0=10, REG_A1=11, REG_T3=28), dump state
//   enum dump_state_e {DUMP_IDLE, DUMP_SCAN}.
// - Sub-module regfile_dump_fsm: state, dump_idx counter, handshake; requests entry[idx+1] from the
//   array via a read-index output and receives data in. Array, read/bypass muxing and taps stay in top.
// TESTING
// - Reset: write x5=0xDEADBEEF, assert rst_n=0 one cycle with we=1 to x5 -> x5 reads 0, all taps 0.
// - x0: we=1 wr_addr=0 wr_data=0xFFFFFFFF -> rd_data for addr 0 stays 0 on every port.
// - Bypass: we=1 x10=0x12345678, rd_addr[0]=10 same cycle -> rd_data[0]=0x12345678 (BYPASS=1),
//   old value (BYPASS=0); tap a0 updates one cycle later.
// - Multi-port alias: NUM_RD=3, all ports read x11=0xA5A5A5A5 -> all three return 0xA5A5A5A5.
// - Dump, ready=1: preload x_i = i*4, pulse start -> 32 beats, idx 0..31, data 0,4,..,124, last on 31
//   only, busy drops the cycle after beat 31; second start during busy ignored.
// - Dump backpressure + reset: ready toggles 1/0 randomly, write x3=0x77 while beat 3 stalled ->
//   beat 3 data unchanged; rst_n=0 at beat 10 -> valid=0, state IDLE, no further beats.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and its dump engine.
package regfile_pkg;

    // RISC-V ABI register indices used by the default debug taps
    localparam int REG_ZERO = 0;
    localparam int REG_A0   = 10;
    localparam int REG_A1   = 11;
    localparam int REG_T3   = 28;

    // Dump engine states
    typedef enum logic {
        DUMP_IDLE = 1'b0,
        DUMP_SCAN = 1'b1
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump engine: streams every register out, one beat per accepted handshake.
//
// Handshake: a beat is offered while dump_valid is high and is consumed on a
// rising edge where dump_valid && dump_ready. While offered and not consumed,
// dump_idx and dump_data hold steady. dump_valid never drops without a
// transfer except on reset.
//
// The data for the next beat is fetched from the array through fetch_idx while
// the current beat is still on the output, so a new beat is ready every cycle.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dump_start,
    input  logic          dump_ready,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [AW-1:0] fetch_idx,
    input  logic [DW-1:0] fetch_data,
    output dump_state_e   state,
    output logic          dump_valid,
    output logic          dump_last,
    output logic [AW-1:0] dump_idx,
    output logic [DW-1:0] dump_data
);

    localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

    // The array lookup always targets the beat after the one on the output
    assign fetch_idx  = dump_idx + 1'b1;
    assign dump_valid = (state == DUMP_SCAN);
    assign dump_last  = dump_valid && (dump_idx == LAST_IDX);

    // State, beat index and beat snapshot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= DUMP_IDLE;
            dump_idx  <= '0;
            dump_data <= '0;
        end else begin
            case (state)
                DUMP_IDLE: begin
                    if (dump_start) begin
                        state     <= DUMP_SCAN;
                        dump_idx  <= '0;
                        dump_data <= '0;   // x0 is always zero
                    end
                end
                DUMP_SCAN: begin
                    if (dump_ready) begin
                        if (dump_idx == LAST_IDX) begin
                            state <= DUMP_IDLE;
                        end else begin
                            dump_idx <= fetch_idx;
                            // fetch_idx is never 0 here, so a matching write always lands
                            dump_data <= (we && (wr_addr == fetch_idx)) ? wr_data : fetch_data;
                        end
                    end
                end
                default: state <= DUMP_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port RISC-V integer register file: x0 hardwired to zero, synchronous
// clear, NUM_RD combinational read ports with optional write bypass, fixed
// debug taps and a streaming dump engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_RD        = 2,
    parameter int BYPASS        = 1,
    parameter int NUM_TAPS      = 3,
    parameter logic [NUM_TAPS*ADDRESS_WIDTH-1:0] TAP_ADDRS =
        {ADDRESS_WIDTH'(REG_T3), ADDRESS_WIDTH'(REG_A1), ADDRESS_WIDTH'(REG_A0)}
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
    input  logic                           we,
    input  logic [ADDRESS_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    output logic [NUM_TAPS*DATA_WIDTH-1:0]  tap,
    input  logic                           dump_start,
    output logic                           dump_busy,
    output logic                           dump_valid,
    input  logic                           dump_ready,
    output logic [ADDRESS_WIDTH-1:0]        dump_idx,
    output logic [DATA_WIDTH-1:0]           dump_data,
    output logic                           dump_last
);

    localparam int AW    = ADDRESS_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

    logic [DW-1:0] regs [DEPTH];
    logic [AW-1:0] fetch_idx;
    logic [DW-1:0] fetch_data;
    dump_state_e   dump_state;

    // Register array: synchronous clear wins over writes, x0 is never written
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wr_addr != ZERO_IDX)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports: zero for x0, optional same-cycle write forwarding, else array
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr[p*AW +: AW];
        assign rd_data[p*DW +: DW] =
            (a == ZERO_IDX)                        ? '0 :
            ((BYPASS != 0) && we && (wr_addr == a)) ? wr_data :
                                                     regs[a];
    end

    // Debug taps show the stored value only, never the in-flight write
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        localparam logic [AW-1:0] TA = TAP_ADDRS[k*AW +: AW];
        assign tap[k*DW +: DW] = (TA == ZERO_IDX) ? '0 : regs[TA];
    end

    assign fetch_data = regs[fetch_idx];
    assign dump_busy  = (dump_state != DUMP_IDLE);

    regfile_dump_fsm #(
        .AW (AW),
        .DW (DW)
    ) u_dump (
        .clk        (clk),
        .rst_n      (rst_n),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .fetch_idx  (fetch_idx),
        .fetch_data (fetch_data),
        .state      (dump_state),
        .dump_valid (dump_valid),
        .dump_last  (dump_last),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing 3-read-port instance and a non-bypassing
// 1-port instance share stimulus; a register-level model is compared against
// both every cycle, with directed literal checks at key points.
module tb_regfile_mp;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NRD   = 3;
    localparam int NT    = 3;
    localparam int DEPTH = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*DW-1:0]   rd_data;
    logic                we;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic [NT*DW-1:0]    tap;
    logic                dump_start;
    logic                dump_busy;
    logic                dump_valid;
    logic                dump_ready;
    logic [AW-1:0]       dump_idx;
    logic [DW-1:0]       dump_data;
    logic                dump_last;

    logic [AW-1:0]       rd_addr_nb;
    logic [DW-1:0]       rd_data_nb;
    logic [NT*DW-1:0]    tap_nb;
    logic                busy_nb, valid_nb, last_nb;
    logic [AW-1:0]       idx_nb;
    logic [DW-1:0]       data_nb;

    assign rd_addr_nb = rd_addr[AW-1:0];

    regfile_mp #(.NUM_RD(NRD), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .tap(tap),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_last(dump_last)
    );

    regfile_mp #(.NUM_RD(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr_nb), .rd_data(rd_data_nb),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .tap(tap_nb),
        .dump_start(dump_start), .dump_busy(busy_nb), .dump_valid(valid_nb),
        .dump_ready(dump_ready), .dump_idx(idx_nb), .dump_data(data_nb),
        .dump_last(last_nb)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;
    int tap_list [NT] = '{10, 11, 28};

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Register contents plus the dump stream seen as "which beat is on offer
    // and what value did register idx hold when that beat was taken".
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy = 1'b0;
    int            m_idx  = 0;
    logic [DW-1:0] m_data = '0;
    bit            m_accept;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_busy = 1'b0;
            m_idx  = 0;
            m_data = '0;
        end else begin
            m_accept = m_busy && dump_ready;
            if (we && wr_addr != 0) m_regs[wr_addr] = wr_data;
            if (!m_busy) begin
                if (dump_start) begin
                    m_busy = 1'b1;
                    m_idx  = 0;
                    m_data = '0;
                end
            end else if (m_accept) begin
                if (m_idx == DEPTH - 1) begin
                    m_busy = 1'b0;
                end else begin
                    m_idx  = m_idx + 1;
                    m_data = m_regs[m_idx];   // already includes this edge's write
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checking) begin
            for (int p = 0; p < NRD; p++) begin
                check($sformatf("rd_data[%0d]", p), rd_data[p*DW +: DW],
                      model_read(rd_addr[p*AW +: AW], 1'b1));
            end
            check("rd_data_nobypass", rd_data_nb, model_read(rd_addr[AW-1:0], 1'b0));
            for (int k = 0; k < NT; k++) begin
                check($sformatf("tap[%0d]", k), tap[k*DW +: DW], m_regs[tap_list[k]]);
            end
            check("dump_busy", 32'(dump_busy), 32'(m_busy));
            check("dump_valid", 32'(dump_valid), 32'(m_busy));
            check("dump_last", 32'(dump_last), 32'(m_busy && m_idx == DEPTH - 1));
            if (m_busy) begin
                check("dump_idx", 32'(dump_idx), 32'(m_idx));
                check("dump_data", dump_data, m_data);
            end
        end
    end

    // ---------------- beat logger / scoreboard ----------------
    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;
    beat_t         got_q [$];
    logic [DW-1:0] exp_q [$];

    always @(negedge clk) begin
        if (checking && dump_valid && dump_ready) begin
            got_q.push_back('{idx: dump_idx, data: dump_data, last: dump_last});
        end
    end

    // ---------------- directed stimulus ----------------
    bit reached;
    bit stalled;

    initial begin
        rst_n      = 1'b0;
        rd_addr    = '0;
        we         = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
        checking = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_valid", 32'(dump_valid), 32'd0);
        check("reset_busy", 32'(dump_busy), 32'd0);
        check("reset_idx", 32'(dump_idx), 32'd0);
        check("reset_data", dump_data, 32'd0);
        check("reset_tap", tap[DW-1:0] | tap[2*DW-1:DW] | tap[3*DW-1:2*DW], 32'd0);
        tick();

        // Reset overrides a same-cycle write
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        we = 1'b0; rd_addr = {5'd0, 5'd0, 5'd5};
        @(negedge clk);
        check("x5_written", rd_data[DW-1:0], 32'hDEADBEEF);
        tick();
        rst_n = 1'b0; we = 1'b1; wr_addr = 5'd5; wr_data = 32'h11111111;
        tick();
        rst_n = 1'b1; we = 1'b0;
        @(negedge clk);
        check("x5_after_reset", rd_data[DW-1:0], 32'd0);
        check("taps_after_reset", tap[DW-1:0] | tap[2*DW-1:DW] | tap[3*DW-1:2*DW], 32'd0);
        tick();

        // Writes to x0 are dropped
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr = '0;
        @(negedge clk);
        for (int p = 0; p < NRD; p++) check("x0_same_cycle", rd_data[p*DW +: DW], 32'd0);
        tick();
        we = 1'b0;
        @(negedge clk);
        for (int p = 0; p < NRD; p++) check("x0_after", rd_data[p*DW +: DW], 32'd0);
        tick();

        // Bypass vs registered-only read; tap a0 lags by one cycle
        we = 1'b1; wr_addr = 5'd10; wr_data = 32'h12345678; rd_addr = {5'd0, 5'd0, 5'd10};
        @(negedge clk);
        check("bypass_read", rd_data[DW-1:0], 32'h12345678);
        check("nobypass_read", rd_data_nb, 32'd0);
        check("tap_a0_before", tap[DW-1:0], 32'd0);
        tick();
        we = 1'b0;
        @(negedge clk);
        check("tap_a0_after", tap[DW-1:0], 32'h12345678);
        check("nobypass_after", rd_data_nb, 32'h12345678);
        tick();

        // All ports alias the same register
        we = 1'b1; wr_addr = 5'd11; wr_data = 32'hA5A5A5A5;
        tick();
        we = 1'b1; wr_addr = 5'd28; wr_data = 32'h0BADF00D; rd_addr = {5'd11, 5'd11, 5'd11};
        @(negedge clk);
        for (int p = 0; p < NRD; p++) check("alias_x11", rd_data[p*DW +: DW], 32'hA5A5A5A5);
        check("tap_a1", tap[2*DW-1:DW], 32'hA5A5A5A5);
        tick();
        we = 1'b0;
        @(negedge clk);
        check("tap_t3", tap[3*DW-1:2*DW], 32'h0BADF00D);
        tick();

        // Preload x_i = i*4
        for (int i = 1; i < DEPTH; i++) begin
            we = 1'b1; wr_addr = AW'(i); wr_data = 32'(i * 4);
            tick();
        end
        we = 1'b0;

        // Dump with ready held high; extra start mid-stream; write into beat 8 as it is fetched
        got_q.delete();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0; dump_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            dump_start = dump_valid && (dump_idx == 5'd5);
            we         = dump_valid && (dump_idx == 5'd7);
            wr_addr    = 5'd8;
            wr_data    = 32'hCAFE0008;
            tick();
        end
        we = 1'b0; dump_start = 1'b0;
        @(negedge clk);
        check("dump1_busy_end", 32'(dump_busy), 32'd0);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back((i == 8) ? 32'hCAFE0008 : 32'(i * 4));
        check("dump1_beats", 32'(got_q.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
            check($sformatf("beat%0d_idx", i), 32'(got_q[i].idx), 32'(i));
            check($sformatf("beat%0d_data", i), got_q[i].data, exp_q[i]);
            check($sformatf("beat%0d_last", i), 32'(got_q[i].last), 32'(i == DEPTH - 1));
        end
        exp_q.delete();
        tick();

        // Backpressure, write to a stalled beat, then reset mid-stream
        got_q.delete();
        dump_start = 1'b1; dump_ready = 1'b0;
        tick();
        dump_start = 1'b0;
        rd_addr = {5'd0, 5'd0, 5'd3};
        reached = 1'b0;
        stalled = 1'b0;
        for (int c = 0; c < 400 && !reached; c++) begin
            if (dump_valid && dump_idx == 5'd3 && !stalled) begin
                dump_ready = 1'b0; we = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
                stalled = 1'b1;
                tick();
                we = 1'b0;
                @(negedge clk);
                check("stall_beat3_idx", 32'(dump_idx), 32'd3);
                check("stall_beat3_data", dump_data, 32'd12);
                check("x3_new_value", rd_data[DW-1:0], 32'h77);
                tick();
            end else if (dump_valid && dump_idx == 5'd10) begin
                rst_n = 1'b0; dump_ready = 1'b1;
                tick();
                rst_n = 1'b1;
                got_q.delete();
                reached = 1'b1;
            end else begin
                dump_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        if (!reached) begin
            n_checks++;
            n_fail++;
            $display("FAIL bp_reach_beat10: beat 10 not offered within 400 cycles, required offered");
        end
        check("bp_stall_seen", 32'(stalled), 32'd1);
        @(negedge clk);
        check("abort_valid", 32'(dump_valid), 32'd0);
        check("abort_busy", 32'(dump_busy), 32'd0);
        check("abort_idx", 32'(dump_idx), 32'd0);
        check("abort_data", dump_data, 32'd0);
        check("abort_x3", rd_data[DW-1:0], 32'd0);
        tick();
        dump_ready = 1'b1;
        for (int c = 0; c < 40; c++) tick();
        check("abort_no_beats", 32'(got_q.size()), 32'd0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
